// File: rtl/otter_instr_encoder_if.sv
// Field-bundle input and instruction-memory write port of the RV32I encoder.
// master: bundle producer / memory model, slave: the encoder.
interface otter_instr_encoder_if #(
  parameter int ADDR_W = 14
);
  logic              IN_VALID;
  logic              IN_READY;
  logic [1:0]        FMT;
  logic [4:0]        RD;
  logic [4:0]        RS1;
  logic [4:0]        RS2;
  logic [2:0]        FUNCT;
  logic              THIRTY;
  logic [31:0]       IMM;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_DIN;
  logic              MEM_ACK;
  logic              WR_DONE;
  logic              ERR;
  logic [ADDR_W-1:0] COUNT;

  modport master (
    output IN_VALID, FMT, RD, RS1, RS2, FUNCT, THIRTY, IMM, MEM_ACK,
    input  IN_READY, MEM_WE, MEM_ADDR, MEM_DIN, WR_DONE, ERR, COUNT
  );

  modport slave (
    input  IN_VALID, FMT, RD, RS1, RS2, FUNCT, THIRTY, IMM, MEM_ACK,
    output IN_READY, MEM_WE, MEM_ADDR, MEM_DIN, WR_DONE, ERR, COUNT
  );
endinterface

// File: rtl/otter_instr_encoder.sv
// Packs RV32I fields (R / I-ALU / B / LUI) into a word and writes it to memory; write strobe 2 cycles after accept.
// Accepts only in IDLE; a write is held until MEM_ACK, illegal bundles raise sticky ERR and are dropped.
module otter_instr_encoder #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                  CLK,
  input logic                  RST,
  otter_instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  localparam logic [1:0]        FMT_R   = 2'b00;
  localparam logic [1:0]        FMT_I   = 2'b01;
  localparam logic [1:0]        FMT_B   = 2'b10;
  localparam logic [1:0]        FMT_LUI = 2'b11;
  localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [1:0]        fmt_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [2:0]        funct_q;
  logic              thirty_q;
  logic [31:0]       imm_q;
  logic [31:0]       word;
  logic              illegal;
  logic              i_fits, b_fits;
  logic              we_q, wr_done_q, err_q;
  logic [31:0]       din_q;
  logic [ADDR_W-1:0] addr_q, count_q;

  // Signed range checks: all bits above the sign position must equal it.
  assign i_fits = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign b_fits = (&imm_q[31:12]) | ~(|imm_q[31:12]);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (fmt_q)
      FMT_R: begin
        word    = {1'b0, thirty_q, 5'b0, rs2_q, rs1_q, funct_q, rd_q, 7'b0110011};
        illegal = thirty_q && (funct_q != 3'b000) && (funct_q != 3'b101);
      end
      FMT_I: begin
        if (funct_q == 3'b101) begin
          word    = {1'b0, thirty_q, 5'b0, imm_q[4:0], rs1_q, funct_q, rd_q, 7'b0010011};
          illegal = |imm_q[31:5];
        end else if (funct_q == 3'b001) begin
          word    = {7'b0, imm_q[4:0], rs1_q, funct_q, rd_q, 7'b0010011};
          illegal = (|imm_q[31:5]) || thirty_q;
        end else begin
          word    = {imm_q[11:0], rs1_q, funct_q, rd_q, 7'b0010011};
          illegal = !i_fits;
        end
      end
      FMT_B: begin
        word    = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct_q, imm_q[4:1], imm_q[11], 7'b1100011};
        illegal = imm_q[0] || !b_fits || (funct_q == 3'b010) || (funct_q == 3'b011);
      end
      FMT_LUI: begin
        word    = {imm_q[31:12], rd_q, 7'b0110111};
        illegal = |imm_q[11:0];
      end
      default: begin
        word    = '0;
        illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.IN_VALID) state_d = ENC;
      ENC:     state_d = illegal ? IDLE : WR;
      WR:      if (bus.MEM_ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fmt_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct_q   <= '0;
      thirty_q  <= 1'b0;
      imm_q     <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= BASE_ADDR;
      count_q   <= '0;
    end else begin
      wr_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.IN_VALID) begin
            fmt_q    <= bus.FMT;
            rd_q     <= bus.RD;
            rs1_q    <= bus.RS1;
            rs2_q    <= bus.RS2;
            funct_q  <= bus.FUNCT;
            thirty_q <= bus.THIRTY;
            imm_q    <= bus.IMM;
          end
        end
        ENC: begin
          if (illegal) begin
            err_q <= 1'b1;
          end else begin
            din_q <= word;
            we_q  <= 1'b1;
          end
        end
        WR: begin
          if (bus.MEM_ACK) begin
            we_q      <= 1'b0;
            wr_done_q <= 1'b1;
            addr_q    <= addr_q + ONE;
            count_q   <= count_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY = (state_q == IDLE) && !RST;
  assign bus.MEM_WE   = we_q;
  assign bus.MEM_ADDR = addr_q;
  assign bus.MEM_DIN  = din_q;
  assign bus.WR_DONE  = wr_done_q;
  assign bus.ERR      = err_q;
  assign bus.COUNT    = count_q;

endmodule

// File: doc/otter_instr_encoder.md
# otter_instr_encoder

Sequential RV32I instruction encoder and program-memory writer for the OTTER test infrastructure. It accepts decoded instruction fields (format, registers, FUNCT, THIRTY, immediate) over a valid/ready handshake and packs them into a 32-bit machine word in the same four formats the control decoder consumes: R-type, I-type ALU, B-type and LUI. It then writes that word to instruction memory at an auto-incrementing word address. Illegal field combinations are flagged and never written.

## Interface
- ADDR_W, 14: word-address width of MEM_ADDR and COUNT.
- BASE_ADDR, 0: MEM_ADDR value after reset.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
- IN_VALID  in  1  field bundle valid.
- IN_READY  out  1  encoder can accept a bundle.
- FMT  in  2  00 R-type, 01 I-type ALU, 10 B-type, 11 LUI.
- RD, RS1, RS2  in  5 each  register indices; unused fields are ignored per format.
- FUNCT  in  3  funct3.
- THIRTY  in  1  instruction bit 30 (SUB/SRA/SRAI select).
- IMM  in  32  signed immediate; for LUI this is the full 32-bit value.
- MEM_WE  out  1  memory write strobe.
- MEM_ADDR  out  ADDR_W  word write address.
- MEM_DIN  out  32  encoded instruction.
- MEM_ACK  in  1  memory accepted the write this cycle.
- WR_DONE  out  1  one-cycle pulse when a write completes.
- ERR  out  1  sticky illegal-encoding flag; cleared only by RST.
- COUNT  out  ADDR_W  number of words written, modulo 2^ADDR_W.

## Operation
- FSM states:
  - IDLE: IN_READY=1. On IN_VALID, capture all fields and go to ENC.
  - ENC: build the word into MEM_DIN and run the legality check.
    - Legal: go to WR.
    - Illegal: set ERR and return to IDLE. No write occurs, and MEM_ADDR and COUNT are unchanged.
  - WR: hold MEM_WE=1 with MEM_ADDR and MEM_DIN stable until MEM_ACK=1 is sampled. On that edge:
    - pulse WR_DONE,
    - increment MEM_ADDR (wrapping from 2^ADDR_W-1 to 0),
    - increment COUNT,
    - clear MEM_WE,
    - go to IDLE.
- IN_READY=0 in ENC and WR. Inputs are not sampled there.
- Encodings (bit ranges of the instruction):
  - R: {1'b0, THIRTY, 5'b0, RS2, RS1, FUNCT, RD, 7'b0110011}.
  - I, FUNCT=101: {1'b0, THIRTY, 5'b0, IMM[4:0], RS1, FUNCT, RD, 7'b0010011}.
  - I, FUNCT=001: {7'b0, IMM[4:0], RS1, FUNCT, RD, 7'b0010011}.
  - I, other FUNCT: {IMM[11:0], RS1, FUNCT, RD, 7'b0010011}. THIRTY is ignored.
  - B: {IMM[12], IMM[10:5], RS2, RS1, FUNCT, IMM[4:1], IMM[11], 7'b1100011}.
  - LUI: {IMM[31:12], RD, 7'b0110111}.
- Illegal conditions (set ERR):
  - I shift (001/101) with IMM[31:5] != 0.
  - I, FUNCT=001, with THIRTY=1.
  - I non-shift with IMM outside [-2048, 2047] as signed 32-bit.
  - B with IMM[0]=1.
  - B with IMM outside [-4096, 4094].
  - B with FUNCT of 010 or 011.
  - LUI with IMM[11:0] != 0.
  - R with THIRTY=1 and FUNCT not in {000, 101}.
- Once set, ERR does not block later bundles; they are processed normally.

## Timing
- Reset values: MEM_WE=0, MEM_ADDR=BASE_ADDR, MEM_DIN=0, WR_DONE=0, ERR=0, COUNT=0, state IDLE.
  - IN_READY=0 during any cycle with RST=1, and 1 from the first cycle after RST deasserts.
- Handshake at edge N (IN_VALID & IN_READY):
  - ENC occupies cycle N+1.
  - MEM_WE rises in cycle N+2, with MEM_DIN valid in that same cycle.
- With MEM_ACK tied high, one word is written every 3 cycles. Each extra cycle of MEM_ACK=0 adds one cycle.
- MEM_ACK is ignored outside WR.
- WR_DONE is high for exactly the cycle after the accepting edge, which is the cycle the FSM is back in IDLE. MEM_ADDR and COUNT show their new values in that same cycle.
- A new IN_VALID may be accepted in that same IDLE cycle; there is no dead cycle.
- Illegal bundle: ERR rises in cycle N+2 and IN_READY returns in cycle N+2.
- RST asserted in ENC or WR:
  - the pending write is abandoned, and MEM_WE=0 from the next cycle,
  - MEM_ADDR returns to BASE_ADDR.
- RST has priority over every other event at the same edge.

## Test plan
- R-type add (RD=3, RS1=1, RS2=2, FUNCT=000, THIRTY=0) -> MEM_DIN=0x002081B3 at addr 0. The same with THIRTY=1 -> 0x402081B3 at addr 1. COUNT=2 afterwards.
- I-type with MEM_ACK held low 4 cycles:
  - addi (RD=1, RS1=0, IMM=-1) -> 0xFFF00093; MEM_WE and MEM_DIN stay stable through the stall, then exactly one WR_DONE pulse.
  - srai (RD=5, RS1=6, IMM=3, FUNCT=101, THIRTY=1) -> 0x40335293.
- B-type beq (RS1=1, RS2=2, IMM=-8) -> 0xFE208CE3. LUI (RD=10, IMM=0x12345000) -> 0x12345537.
- Illegal bundles:
  - B with IMM=3 -> ERR=1, no MEM_WE, MEM_ADDR unchanged.
  - Then addi IMM=4096 -> also rejected.
  - Then a legal bundle -> written at the unchanged address.
- Wrap: ADDR_W=2, BASE_ADDR=3, two legal writes -> addresses 3 then 0, COUNT=2.
- RST asserted during WR with MEM_ACK=0 -> MEM_WE=0 next cycle, MEM_ADDR=BASE_ADDR, COUNT=0, ERR=0, and no WR_DONE.
